calc_entry_ctrl: RTL

Keypad-to-register-file sequencer for the calculator. It turns one-cycle key events into decimal operand entry, operator selection, backspace and clear. It writes operands, operator and result into the 8-bit register file through its single write port. It also starts the ALU and supervises it until it completes, errors or times out.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/calc_entry_ctrl_if.sv | 29 ++
 rtl/calc_digit_acc.sv | 23 ++
 rtl/calc_entry_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, register map and state encoding for calc_entry_ctrl
package calc_pkg;

    localparam logic [4:0] KEY_ADD = 5'd10;
    localparam logic [4:0] KEY_SUB = 5'd11;
    localparam logic [4:0] KEY_MUL = 5'd12;
    localparam logic [4:0] KEY_DIV = 5'd13;
    localparam logic [4:0] KEY_EQ  = 5'd14;
    localparam logic [4:0] KEY_DEL = 5'd15;
    localparam logic [4:0] KEY_CLR = 5'd16;

    localparam int RA_A   = 0;
    localparam int RA_B   = 1;
    localparam int RA_RES = 2;
    localparam int RA_OP  = 3;

    typedef enum logic [2:0] {
        S_A     = 3'd0,
        S_B     = 3'd1,
        S_WAIT  = 3'd2,
        S_RES   = 3'd3,
        S_CHAIN = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    function automatic logic key_is_op(input logic [4:0] code);
        return (code >= KEY_ADD) && (code <= KEY_DIV);
    endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// rtl/calc_entry_ctrl_if.sv - key, ALU and register-file signals of calc_entry_ctrl
interface calc_entry_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              key_valid;
    logic [4:0]        key_code;
    logic              alu_done;
    logic              alu_err;
    logic [DATA_W-1:0] alu_result;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_clr;
    logic              alu_start;
    logic              busy;
    logic              error;
    logic [2:0]        state_o;

    modport master (
        output key_valid, key_code, alu_done, alu_err, alu_result,
        input  rf_we, rf_waddr, rf_wdata, rf_clr, alu_start, busy, error, state_o
    );

    modport slave (
        input  key_valid, key_code, alu_done, alu_err, alu_result,
        output rf_we, rf_waddr, rf_wdata, rf_clr, alu_start, busy, error, state_o
    );
endinterface

// File: rtl/calc_digit_acc.sv
// rtl/calc_digit_acc.sv - decimal digit append (acc*10+d) with limits, and backspace (acc/10)
module calc_digit_acc #(
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 2,
    parameter int MAX_DIGITS = 3
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [CNT_W-1:0]  cnt,
    input  logic [3:0]        digit,
    output logic              push_ok,
    output logic [DATA_W-1:0] push_acc,
    output logic [DATA_W-1:0] pop_acc
);
    logic [DATA_W+3:0] wide;

    always_comb begin
        // Four extra bits hold acc*10+9 for any acc, so overflow is just a non-zero top nibble.
        wide     = {4'd0, acc} * (DATA_W + 4)'(10) + {{DATA_W{1'b0}}, digit};
        push_ok  = (cnt < CNT_W'(MAX_DIGITS)) && (wide[DATA_W+3:DATA_W] == 4'd0);
        push_acc = wide[DATA_W-1:0];
        pop_acc  = acc / DATA_W'(10);
    end
endmodule

// File: rtl/calc_entry_ctrl.sv
// rtl/calc_entry_ctrl.sv - keypad-to-register-file sequencer that drives and supervises the ALU
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int MAX_DIGITS  = 3,
    parameter int ALU_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    calc_entry_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TMR_W = $clog2(ALU_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d, res_q, res_d;
    logic [CNT_W-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [4:0]        op_q, op_d;
    logic              chain_ph_q, chain_ph_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              rf_we_q, rf_we_d, rf_clr_q, rf_clr_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              alu_start_q, alu_start_d, busy_q, busy_d, error_q, error_d;

    logic              in_b, is_digit, is_op, is_eq, is_del, is_clr;
    logic [DATA_W-1:0] cur_acc, nxt_acc, push_acc, pop_acc;
    logic [CNT_W-1:0]  cur_cnt, nxt_cnt;
    logic [ADDR_W-1:0] cur_addr;
    logic              push_ok;

    assign in_b     = (state_q == S_B);
    assign cur_acc  = in_b ? acc_b_q : acc_a_q;
    assign cur_cnt  = in_b ? cnt_b_q : cnt_a_q;
    assign cur_addr = in_b ? ADDR_W'(RA_B) : ADDR_W'(RA_A);
    assign is_digit = (bus.key_code <= 5'd9);
    assign is_op    = key_is_op(bus.key_code);
    assign is_eq    = (bus.key_code == KEY_EQ);
    assign is_del   = (bus.key_code == KEY_DEL);
    assign is_clr   = (bus.key_code == KEY_CLR);

    calc_digit_acc #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .MAX_DIGITS(MAX_DIGITS)
    ) u_digit_acc (
        .acc     (cur_acc),
        .cnt     (cur_cnt),
        .digit   (bus.key_code[3:0]),
        .push_ok (push_ok),
        .push_acc(push_acc),
        .pop_acc (pop_acc)
    );

    always_comb begin
        state_d     = state_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        res_d       = res_q;
        op_d        = op_q;
        chain_ph_d  = chain_ph_q;
        timer_d     = timer_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = '0;
        rf_wdata_d  = '0;
        rf_clr_d    = 1'b0;
        alu_start_d = 1'b0;
        nxt_acc     = cur_acc;
        nxt_cnt     = cur_cnt;

        // CLR pre-empts everything, including a same-cycle alu_done and a pending chain write.
        if (bus.key_valid && is_clr) begin
            rf_clr_d   = 1'b1;
            state_d    = S_A;
            acc_a_d    = '0;
            acc_b_d    = '0;
            cnt_a_d    = '0;
            cnt_b_d    = '0;
            res_d      = '0;
            op_d       = '0;
            chain_ph_d = 1'b0;
            timer_d    = '0;
        end else begin
            unique case (state_q)
                S_A, S_B: begin
                    if (bus.key_valid) begin
                        if (is_digit) begin
                            if (push_ok) begin
                                nxt_acc    = push_acc;
                                nxt_cnt    = cur_cnt + 1'b1;
                                rf_we_d    = 1'b1;
                                rf_waddr_d = cur_addr;
                                rf_wdata_d = push_acc;
                            end
                        end else if (is_op) begin
                            if (in_b ? (cur_cnt == '0) : (cur_cnt != '0)) begin
                                op_d       = bus.key_code;
                                rf_we_d    = 1'b1;
                                rf_waddr_d = ADDR_W'(RA_OP);
                                rf_wdata_d = DATA_W'(bus.key_code);
                                state_d    = S_B;
                            end
                        end else if (is_eq) begin
                            if (in_b && (cur_cnt != '0)) begin
                                alu_start_d = 1'b1;
                                timer_d     = '0;
                                state_d     = S_WAIT;
                            end
                        end else if (is_del) begin
                            if (cur_cnt != '0) begin
                                nxt_acc    = pop_acc;
                                nxt_cnt    = cur_cnt - 1'b1;
                                rf_we_d    = 1'b1;
                                rf_waddr_d = cur_addr;
                                rf_wdata_d = pop_acc;
                            end else if (in_b) begin
                                state_d = S_A;
                            end
                        end
                    end
                    if (in_b) begin
                        acc_b_d = nxt_acc;
                        cnt_b_d = nxt_cnt;
                    end else begin
                        acc_a_d = nxt_acc;
                        cnt_a_d = nxt_cnt;
                    end
                end
                S_WAIT: begin
                    timer_d = timer_q + 1'b1;
                    if (bus.alu_done) begin
                        if (!bus.alu_err) begin
                            res_d      = bus.alu_result;
                            rf_we_d    = 1'b1;
                            rf_waddr_d = ADDR_W'(RA_RES);
                            rf_wdata_d = bus.alu_result;
                            state_d    = S_RES;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if (timer_d == TMR_W'(ALU_TIMEOUT)) begin
                        state_d = S_ERR;
                    end
                end
                S_RES: begin
                    if (bus.key_valid && is_digit) begin
                        acc_a_d    = DATA_W'(bus.key_code[3:0]);
                        cnt_a_d    = CNT_W'(1);
                        acc_b_d    = '0;
                        cnt_b_d    = '0;
                        rf_we_d    = 1'b1;
                        rf_waddr_d = ADDR_W'(RA_A);
                        rf_wdata_d = DATA_W'(bus.key_code[3:0]);
                        state_d    = S_A;
                    end else if (bus.key_valid && is_op) begin
                        // Result becomes a full-length A so no further digits can extend it.
                        acc_a_d    = res_q;
                        cnt_a_d    = CNT_W'(MAX_DIGITS);
                        acc_b_d    = '0;
                        cnt_b_d    = '0;
                        op_d       = bus.key_code;
                        chain_ph_d = 1'b0;
                        rf_we_d    = 1'b1;
                        rf_waddr_d = ADDR_W'(RA_A);
                        rf_wdata_d = res_q;
                        state_d    = S_CHAIN;
                    end
                end
                S_CHAIN: begin
                    if (!chain_ph_q) begin
                        chain_ph_d = 1'b1;
                        rf_we_d    = 1'b1;
                        rf_waddr_d = ADDR_W'(RA_OP);
                        rf_wdata_d = DATA_W'(op_q);
                    end else begin
                        state_d = S_B;
                    end
                end
                default: ;
            endcase
        end

        busy_d  = (state_d == S_WAIT) || (state_d == S_CHAIN);
        error_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_A;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            res_q       <= '0;
            op_q        <= '0;
            chain_ph_q  <= 1'b0;
            timer_q     <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            rf_clr_q    <= 1'b0;
            alu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            res_q       <= res_d;
            op_q        <= op_d;
            chain_ph_q  <= chain_ph_d;
            timer_q     <= timer_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_clr_q    <= rf_clr_d;
            alu_start_q <= alu_start_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.rf_clr    = rf_clr_q;
    assign bus.alu_start = alu_start_q;
    assign bus.busy      = busy_q;
    assign bus.error     = error_q;
    assign bus.state_o   = state_q;
endmodule
